// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the six-lamp bus of the traffic
// light controller. Decodes the phase, times each phase, and flags illegal
// lamp patterns, bad phase orderings, short greens and flash (blink) mode.
// Optional build macro TRAFFIC_MON_STICKY_EN adds err_clr / err_status, a
// sticky record of {short_green, seq_err, illegal}.
//
// state  | meaning
// DARK   | all lamps off (also one half of flash)
// PG     | primary green, secondary red
// PY     | primary yellow (secondary red, or alone when flashing)
// SG     | secondary green, primary red
// SY     | secondary yellow, primary red
// ALLRED | both directions red
// ILLEGAL| any other lamp pattern
module traffic_light_monitor #(
  parameter int DWELL_W       = 16,
  parameter int MIN_GREEN     = 4,
  parameter int FLASH_TOGGLES = 4
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic [5:0]         lamp,
`ifdef TRAFFIC_MON_STICKY_EN
  input  logic               err_clr,
  output logic [2:0]         err_status,
`endif
  output logic [2:0]         phase,
  output logic               phase_chg,
  output logic [DWELL_W-1:0] dwell,
  output logic [DWELL_W-1:0] last_dwell,
  output logic               illegal,
  output logic               seq_err,
  output logic               short_green,
  output logic [7:0]         err_count,
  output logic               flash_mode
);

  typedef enum logic [2:0] {
    DARK    = 3'd0,
    PG      = 3'd1,
    PY      = 3'd2,
    SG      = 3'd3,
    SY      = 3'd4,
    ALLRED  = 3'd5,
    ILLEGAL = 3'd7
  } phase_t;

  localparam int FW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [FW-1:0] FT = FW'(FLASH_TOGGLES);

  logic [5:0]    lamp_q;
  phase_t        phase_q;
  phase_t        dec;
  logic          side_s;   // 0: next green after ALLRED is primary, 1: secondary
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nx;
  logic          chg;
  logic          legal;
  logic          ill_n;
  logic          se_n;
  logic          sg_n;
  logic          flash_edge;

  assign phase = phase_q;

  // Decode the registered lamp pattern; unlisted lamps must be off.
  always_comb begin
    dec = ILLEGAL;
    case (lamp_q)
      6'b000000: dec = DARK;
      6'b010010: dec = PG;
      6'b011000: dec = PY;
      6'b001000: dec = PY;     // yellow alone: flash pattern
      6'b100001: dec = SG;
      6'b100100: dec = SY;
      6'b110000: dec = ALLRED;
      default:   dec = ILLEGAL;
    endcase
  end

  // Transition legality, error pulses and flash counter next value.
  always_comb begin
    chg   = (dec != phase_q);
    legal = 1'b0;
    if (dec == DARK || phase_q == DARK || phase_q == ILLEGAL) begin
      legal = 1'b1;
    end else begin
      case (phase_q)
        PG:      legal = (dec == PY);
        PY:      legal = (dec == ALLRED) || (dec == SG);
        SG:      legal = (dec == SY);
        SY:      legal = (dec == ALLRED) || (dec == PG);
        ALLRED:  legal = side_s ? (dec == SG) : (dec == PG);
        default: legal = 1'b0;
      endcase
    end
    ill_n = chg && (dec == ILLEGAL);
    se_n  = chg && !legal && !ill_n;
    sg_n  = chg && (((phase_q == PG) && (dec == PY)) || ((phase_q == SG) && (dec == SY)))
                && (dwell < DWELL_W'(MIN_GREEN));
    flash_edge = chg && (((phase_q == DARK) && (dec == PY)) || ((phase_q == PY) && (dec == DARK)));
    fcnt_nx = fcnt;
    if (chg) begin
      if (flash_edge) begin
        if (fcnt != '1) fcnt_nx = fcnt + FW'(1);
      end else begin
        fcnt_nx = '0;
      end
    end
  end

  // Lamp capture, phase tracking, dwell timing and registered flags.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      lamp_q      <= '0;
      phase_q     <= DARK;
      phase_chg   <= 1'b0;
      dwell       <= '0;
      last_dwell  <= '0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      short_green <= 1'b0;
      err_count   <= '0;
      flash_mode  <= 1'b0;
      side_s      <= 1'b0;
      fcnt        <= '0;
    end else begin
      lamp_q      <= lamp;
      phase_chg   <= chg;
      illegal     <= ill_n;
      seq_err     <= se_n;
      short_green <= sg_n;
      if (chg) begin
        phase_q    <= dec;
        last_dwell <= dwell;
        dwell      <= DWELL_W'(1);
      end else if (dwell != '1) begin
        dwell <= dwell + DWELL_W'(1);
      end
      if (chg && (phase_q == PG) && (dec == PY)) side_s <= 1'b1;
      else if (chg && (dec == SY))               side_s <= 1'b0;
      fcnt       <= fcnt_nx;
      flash_mode <= (fcnt_nx >= FT);
      if ((ill_n || se_n || sg_n) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

`ifdef TRAFFIC_MON_STICKY_EN
  // Sticky error record; a new pulse wins over a simultaneous clear.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) err_status <= '0;
    else if (err_clr) err_status <= {sg_n, se_n, ill_n};
    else err_status <= err_status | {sg_n, se_n, ill_n};
  end
`endif

endmodule
